// File: rtl/elevator_ctrl_n.sv
// Purpose : N-floor SCAN elevator controller; latches cabin and hall calls, drives engine and per-floor doors.
// Latency : a call sampled at edge k is pending after k and acted on at k+1; a call d floors away opens at k+1+d*TRAVEL_CYC.
// Backpr. : none; panels are sampled on every edge and held in pending until the floor is served.
//
// Ports:
//   FRQ             system clock, rising edge
//   RST             asynchronous active-low reset
//   interior_panel  cabin call buttons, bit i = floor i (level or pulse)
//   exterior_panel  hall call buttons, same encoding
//   engine          00 stop, 01 up, 10 down
//   doors           one-hot open door at the current floor, 0 when closed
//   floor           current cabin floor
//   pending         latched, not yet served calls
module elevator_ctrl_n #(
    parameter int FLOORS     = 4,
    parameter int FLOOR_W    = 2,
    parameter int TRAVEL_CYC = 4,
    parameter int DOOR_CYC   = 3
) (
    input  logic               FRQ,
    input  logic               RST,
    input  logic [FLOORS-1:0]  interior_panel,
    input  logic [FLOORS-1:0]  exterior_panel,
    output logic [1:0]         engine,
    output logic [FLOORS-1:0]  doors,
    output logic [FLOOR_W-1:0] floor,
    output logic [FLOORS-1:0]  pending
);

    localparam int TCNT_W = (TRAVEL_CYC > 1) ? $clog2(TRAVEL_CYC) : 1;
    localparam int DCNT_W = (DOOR_CYC > 1) ? $clog2(DOOR_CYC) : 1;

    localparam logic [TCNT_W-1:0]  TCNT_LAST = TCNT_W'(TRAVEL_CYC - 1);
    localparam logic [DCNT_W-1:0]  DCNT_LAST = DCNT_W'(DOOR_CYC - 1);
    localparam logic [FLOOR_W-1:0] FLOOR_TOP = FLOOR_W'(FLOORS - 1);
    localparam logic [FLOORS-1:0]  FLOOR_ONE = {{(FLOORS-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_MOVE_UP   = 2'd1,
        S_MOVE_DOWN = 2'd2,
        S_DOOR_OPEN = 2'd3
    } state_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

    state_t              state_q, state_d;
    dir_t                dir_q, dir_d;
    logic [FLOOR_W-1:0]  floor_q, floor_d;
    logic [FLOORS-1:0]   pending_q, pending_d;
    logic [TCNT_W-1:0]   tcnt_q, tcnt_d;
    logic [DCNT_W-1:0]   dcnt_q, dcnt_d;

    logic [FLOORS-1:0]   calls;
    logic                here_call;
    logic                ahead;
    logic                above_q;
    logic                below_q;

    // Any call strictly above floor f.
    function automatic logic any_above(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i > int'(f)) begin
                r = r | p[i];
            end
        end
        return r;
    endfunction

    // Any call strictly below floor f.
    function automatic logic any_below(input logic [FLOORS-1:0] p, input logic [FLOOR_W-1:0] f);
        logic r;
        r = 1'b0;
        for (int i = 0; i < FLOORS; i++) begin
            if (i < int'(f)) begin
                r = r | p[i];
            end
        end
        return r;
    endfunction

    // IDLE decisions look only at calls already registered.
    assign above_q = any_above(pending_q, floor_q);
    assign below_q = any_below(pending_q, floor_q);

    always_comb begin
        state_d   = state_q;
        dir_d     = dir_q;
        floor_d   = floor_q;
        tcnt_d    = tcnt_q;
        dcnt_d    = dcnt_q;
        ahead     = 1'b0;
        here_call = 1'b0;
        calls     = interior_panel | exterior_panel;

        // With the door open, a press for this floor only re-arms the dwell
        // timer; it must not leave a stale call behind once the door closes.
        if (state_q == S_DOOR_OPEN) begin
            here_call      = calls[floor_q];
            calls[floor_q] = 1'b0;
        end

        pending_d = pending_q | calls;

        unique case (state_q)
            S_IDLE: begin
                if (pending_q[floor_q]) begin
                    state_d            = S_DOOR_OPEN;
                    dcnt_d             = '0;
                    pending_d[floor_q] = 1'b0;
                end else if (above_q && (dir_q == DIR_UP || !below_q)) begin
                    state_d = S_MOVE_UP;
                    dir_d   = DIR_UP;
                    tcnt_d  = '0;
                end else if (below_q) begin
                    state_d = S_MOVE_DOWN;
                    dir_d   = DIR_DOWN;
                    tcnt_d  = '0;
                end
            end

            S_MOVE_UP, S_MOVE_DOWN: begin
                if (tcnt_q == TCNT_LAST) begin
                    tcnt_d = '0;
                    // Arrival: floor steps, then the decision is taken on the
                    // new floor using calls including those latched this edge.
                    if (state_q == S_MOVE_UP) begin
                        if (floor_q != FLOOR_TOP) begin
                            floor_d = floor_q + FLOOR_W'(1);
                        end
                        ahead = any_above(pending_d, floor_d);
                    end else begin
                        if (floor_q != '0) begin
                            floor_d = floor_q - FLOOR_W'(1);
                        end
                        ahead = any_below(pending_d, floor_d);
                    end

                    if (pending_d[floor_d]) begin
                        state_d            = S_DOOR_OPEN;
                        dcnt_d             = '0;
                        pending_d[floor_d] = 1'b0;
                    end else if (!ahead) begin
                        state_d = S_IDLE;
                    end
                end else begin
                    tcnt_d = tcnt_q + TCNT_W'(1);
                end
            end

            S_DOOR_OPEN: begin
                if (here_call) begin
                    dcnt_d = '0;
                end else if (dcnt_q == DCNT_LAST) begin
                    state_d = S_IDLE;
                    dcnt_d  = '0;
                end else begin
                    dcnt_d = dcnt_q + DCNT_W'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge FRQ or negedge RST) begin
        if (!RST) begin
            state_q   <= S_IDLE;
            dir_q     <= DIR_UP;
            floor_q   <= '0;
            pending_q <= '0;
            tcnt_q    <= '0;
            dcnt_q    <= '0;
        end else begin
            state_q   <= state_d;
            dir_q     <= dir_d;
            floor_q   <= floor_d;
            pending_q <= pending_d;
            tcnt_q    <= tcnt_d;
            dcnt_q    <= dcnt_d;
        end
    end

    assign engine  = (state_q == S_MOVE_UP)   ? 2'b01 :
                     (state_q == S_MOVE_DOWN) ? 2'b10 : 2'b00;
    assign doors   = (state_q == S_DOOR_OPEN) ? (FLOOR_ONE << floor_q) : '0;
    assign floor   = floor_q;
    assign pending = pending_q;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// Purpose : self-checking bench for elevator_ctrl_n with a floor-level behavioural model.
// Latency : model advances on every rising edge; outputs compared on every falling edge.
// Backpr. : none; stimulus is applied freely, one cycle per tick.
module tb_elevator_ctrl_n;

    localparam int NF = 4;
    localparam int TC = 4;
    localparam int DC = 3;

    localparam int PH_IDLE = 0;
    localparam int PH_MOVE = 1;
    localparam int PH_DOOR = 2;

    logic          FRQ = 1'b0;
    logic          RST;
    logic [NF-1:0] interior_panel;
    logic [NF-1:0] exterior_panel;
    logic [1:0]    engine;
    logic [NF-1:0] doors;
    logic [1:0]    floor;
    logic [NF-1:0] pending;

    int vectors     = 0;
    int miscompares = 0;
    bit cmp_en      = 1'b0;

    // Behavioural model: where the cabin is, what it is doing, how many
    // cycles remain of the current activity, and which floors are wanted.
    int m_phase  = PH_IDLE;
    int m_floor  = 0;
    int m_dir    = 1;
    int m_travel = 0;
    int m_door   = 0;
    bit m_pend [NF];

    elevator_ctrl_n #(
        .FLOORS     (NF),
        .FLOOR_W    (2),
        .TRAVEL_CYC (TC),
        .DOOR_CYC   (DC)
    ) dut (
        .FRQ            (FRQ),
        .RST            (RST),
        .interior_panel (interior_panel),
        .exterior_panel (exterior_panel),
        .engine         (engine),
        .doors          (doors),
        .floor          (floor),
        .pending        (pending)
    );

    always #5 FRQ = ~FRQ;

    function automatic bit calls_beyond(input int from, input int step);
        for (int f = from + step; f >= 0 && f < NF; f += step) begin
            if (m_pend[f]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [NF-1:0] model_pending();
        logic [NF-1:0] v;
        for (int i = 0; i < NF; i++) v[i] = m_pend[i];
        return v;
    endfunction

    function automatic logic [1:0] model_engine();
        if (m_phase == PH_MOVE) return (m_dir > 0) ? 2'b01 : 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [NF-1:0] model_doors();
        logic [NF-1:0] v;
        v = '0;
        if (m_phase == PH_DOOR) v[m_floor] = 1'b1;
        return v;
    endfunction

    task automatic model_reset();
        m_phase  = PH_IDLE;
        m_floor  = 0;
        m_dir    = 1;
        m_travel = 0;
        m_door   = 0;
        for (int i = 0; i < NF; i++) m_pend[i] = 1'b0;
    endtask

    task automatic arrive_or_continue();
        if (m_pend[m_floor]) begin
            m_pend[m_floor] = 1'b0;
            m_phase = PH_DOOR;
            m_door  = DC;
        end else if (calls_beyond(m_floor, m_dir)) begin
            m_travel = TC;
        end else begin
            m_phase = PH_IDLE;
        end
    endtask

    task automatic model_step(input logic [NF-1:0] calls);
        bit here, up, dn;
        case (m_phase)
            PH_IDLE: begin
                here = m_pend[m_floor];
                up   = calls_beyond(m_floor, 1);
                dn   = calls_beyond(m_floor, -1);
                for (int i = 0; i < NF; i++) if (calls[i]) m_pend[i] = 1'b1;
                if (here) begin
                    m_pend[m_floor] = 1'b0;
                    m_phase = PH_DOOR;
                    m_door  = DC;
                end else if (up && (m_dir > 0 || !dn)) begin
                    m_phase  = PH_MOVE;
                    m_dir    = 1;
                    m_travel = TC;
                end else if (dn) begin
                    m_phase  = PH_MOVE;
                    m_dir    = -1;
                    m_travel = TC;
                end
            end
            PH_MOVE: begin
                for (int i = 0; i < NF; i++) if (calls[i]) m_pend[i] = 1'b1;
                m_travel--;
                if (m_travel == 0) begin
                    if (m_floor + m_dir >= 0 && m_floor + m_dir < NF) m_floor += m_dir;
                    arrive_or_continue();
                end
            end
            default: begin
                for (int i = 0; i < NF; i++) if (calls[i] && i != m_floor) m_pend[i] = 1'b1;
                if (calls[m_floor]) begin
                    m_door = DC;
                end else begin
                    m_door--;
                    if (m_door == 0) m_phase = PH_IDLE;
                end
            end
        endcase
    endtask

    always @(posedge FRQ or negedge RST) begin
        if (!RST) model_reset();
        else      model_step(interior_panel | exterior_panel);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge FRQ) begin
        if (cmp_en) begin
            chk("cyc_engine",  32'(engine),  32'(model_engine()));
            chk("cyc_doors",   32'(doors),   32'(model_doors()));
            chk("cyc_floor",   32'(floor),   32'(m_floor));
            chk("cyc_pending", 32'(pending), 32'(model_pending()));
        end
    end

    // Inputs set just after a falling edge are sampled by the next rising
    // edge; on return the outputs reflect the previous rising edge.
    task automatic tick(input logic [NF-1:0] ip, input logic [NF-1:0] ep);
        @(negedge FRQ);
        #1;
        interior_panel = ip;
        exterior_panel = ep;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            tick('0, '0);
            n++;
        end while (!(engine == 2'b00 && doors == '0 && pending == '0) && n < 200);
        chk(name, 32'(engine == 2'b00 && doors == '0 && pending == '0), 32'd1);
    endtask

    initial begin
        #1000000;
        miscompares++;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int fl_mid;
        RST            = 1'b0;
        interior_panel = '0;
        exterior_panel = '0;
        repeat (2) @(negedge FRQ);
        cmp_en = 1'b1;

        // 1: calls pressed while held in reset are ignored.
        for (int i = 0; i < 5; i++) begin
            tick(NF'($urandom), NF'($urandom));
            chk("t1_engine",  32'(engine),  32'd0);
            chk("t1_doors",   32'(doors),   32'd0);
            chk("t1_floor",   32'(floor),   32'd0);
            chk("t1_pending", 32'(pending), 32'd0);
        end
        tick('0, '0);
        RST = 1'b1;

        // 3: hall call at the current floor opens the door with no motion.
        tick(4'b0000, 4'b0001);
        tick('0, '0);
        chk("t3_pend",  32'(pending), 32'h1);
        chk("t3_doors_closed", 32'(doors), 32'h0);
        tick('0, '0);
        chk("t3_doors", 32'(doors), 32'h1);
        chk("t3_pend_clr", 32'(pending), 32'h0);
        chk("t3_model_doors", 32'(model_doors()), 32'h1);
        n = 1;
        for (int i = 0; i < 10; i++) begin
            tick('0, '0);
            if (engine != 2'b00) chk("t3_engine", 32'(engine), 32'd0);
            if (doors == 4'b0001) n++;
            else break;
        end
        chk("t3_dwell", 32'(n), 32'd3);
        chk("t3_closed", 32'(doors), 32'h0);

        // 2: cabin call two floors up.
        tick(4'b0100, 4'b0000);
        tick('0, '0);
        chk("t2_pend", 32'(pending), 32'h4);
        chk("t2_model_pend", 32'(model_pending()), 32'h4);
        chk("t2_eng_idle", 32'(engine), 32'd0);
        n = 0;
        fl_mid = -1;
        for (int i = 0; i < 20; i++) begin
            tick('0, '0);
            if (engine == 2'b01) begin
                n++;
                if (n == 5) fl_mid = int'(floor);
            end else begin
                break;
            end
        end
        chk("t2_up_cycles", 32'(n), 32'd8);
        chk("t2_floor_mid", 32'(fl_mid), 32'd1);
        chk("t2_doors", 32'(doors), 32'h4);
        chk("t2_floor", 32'(floor), 32'd2);
        chk("t2_pend_clr", 32'(pending), 32'h0);
        n = 1;
        for (int i = 0; i < 10; i++) begin
            tick('0, '0);
            if (doors == 4'b0100) n++;
            else break;
        end
        chk("t2_dwell", 32'(n), 32'd3);
        chk("t2_engine_end", 32'(engine), 32'd0);
        chk("t2_doors_end", 32'(doors), 32'h0);

        // 5: hall press for the open floor restarts the dwell timer.
        tick(4'b0100, 4'b0000);
        tick('0, '0);
        chk("t5_pend", 32'(pending), 32'h4);
        tick(4'b0000, 4'b0100);
        chk("t5_open", 32'(doors), 32'h4);
        tick('0, '0);
        chk("t5_still_open", 32'(doors), 32'h4);
        chk("t5_no_latch", 32'(pending), 32'h0);
        n = 2;
        for (int i = 0; i < 10; i++) begin
            tick('0, '0);
            if (doors == 4'b0100) n++;
            else break;
        end
        chk("t5_dwell", 32'(n), 32'd4);
        chk("t5_pend_end", 32'(pending), 32'h0);

        // 4: go to floor 1, then head for 3 and collect a call for 0 on the way.
        tick(4'b0010, 4'b0000);
        wait_idle("t4_idle_at_1");
        chk("t4_floor1", 32'(floor), 32'd1);
        tick(4'b1000, 4'b0000);
        tick('0, '0);
        chk("t4_pend3", 32'(pending), 32'h8);
        tick(4'b0001, 4'b0000);
        chk("t4_moving_up", 32'(engine), 32'h1);
        chk("t4_from1", 32'(floor), 32'd1);
        for (int i = 0; i < 30; i++) begin
            tick('0, '0);
            if (doors != '0) break;
        end
        chk("t4_doors3", 32'(doors), 32'h8);
        chk("t4_floor3", 32'(floor), 32'd3);
        chk("t4_pend0", 32'(pending), 32'h1);
        chk("t4_model_floor", 32'(m_floor), 32'd3);
        for (int i = 0; i < 10; i++) begin
            tick('0, '0);
            if (engine == 2'b10) break;
        end
        n = 1;
        for (int i = 0; i < 30; i++) begin
            tick('0, '0);
            if (engine == 2'b10) n++;
            else break;
        end
        chk("t4_down_cycles", 32'(n), 32'd12);
        chk("t4_doors0", 32'(doors), 32'h1);
        chk("t4_floor0", 32'(floor), 32'd0);
        wait_idle("t4_idle_at_0");

        // 6: asynchronous reset while travelling between floors 1 and 2.
        tick(4'b0100, 4'b0000);
        for (int i = 0; i < 20; i++) begin
            tick('0, '0);
            if (floor == 2'd1) break;
        end
        chk("t6_moving", 32'(engine), 32'h1);
        #2 RST = 1'b0;
        #1;
        chk("t6_engine", 32'(engine), 32'd0);
        chk("t6_floor", 32'(floor), 32'd0);
        chk("t6_pending", 32'(pending), 32'd0);
        chk("t6_doors", 32'(doors), 32'd0);
        tick('0, '0);
        RST = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick('0, '0);
            chk("t6_still", 32'({engine, floor}), 32'd0);
        end

        // Randomised traffic with occasional asynchronous resets.
        for (int c = 0; c < 3000; c++) begin
            logic [NF-1:0] ip, ep;
            ip = ($urandom_range(0, 5) == 0) ? NF'($urandom) : '0;
            ep = ($urandom_range(0, 5) == 0) ? NF'($urandom) : '0;
            if ($urandom_range(0, 399) == 0) begin
                #2 RST = 1'b0;
                tick('0, '0);
                RST = 1'b1;
            end
            tick(ip, ep);
        end
        repeat (4) tick('0, '0);
        @(negedge FRQ);
        #1;
        cmp_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
